// File: rtl/kgp_mem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package kgp_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic P_LSU    = 1'b0;
    localparam logic P_LOADER = 1'b1;

    function automatic int unsigned be_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two req/ack ports and shared read data.
interface dmem_arbiter_if
    import kgp_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = be_w(DATA_W);

    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [BE_W-1:0]   we0;
    logic [BE_W-1:0]   we1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1,
        input  ack0, ack1, rdata
    );

    modport slave (
        input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1,
        output ack0, ack1, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-grant register moves only when a grant is taken.
module rr_arb2
    import kgp_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_c
);

    logic last_q;

    // Lone requester wins; under contention the port not granted last wins.
    always_comb begin
        grant_c = P_LSU;
        if (req[0] && req[1]) begin
            grant_c = ~last_q;
        end else if (req[1]) begin
            grant_c = P_LOADER;
        end
    end

    // Reset as if the loader went last so the LSU wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= P_LOADER;
        end else if (update) begin
            last_q <= grant_c;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the LSU (port 0) and the loader (port 1),
// sequencing issue, read-latency wait and completion of one access at a time.
module dmem_arbiter
    import kgp_mem_pkg::*;
#(
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned RD_LAT = 1,
    localparam int unsigned BE_W   = be_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus,
    output logic              busy,
    output logic              owner,
    output logic [BE_W-1:0]   mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    localparam int unsigned CNT_W = 2;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_read_q, is_read_d;
    logic              rd_done_q, rd_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addra_d;
    logic [BE_W-1:0]   wea_d;
    logic [DATA_W-1:0] dina_d;
    logic              owner_d, ack0_d, ack1_d, busy_d;
    logic              start_c, grant_c;

    assign start_c = (state_q == ST_IDLE) && (bus.req0 || bus.req1);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({bus.req1, bus.req0}),
        .update  (start_c),
        .grant_c (grant_c)
    );

    // Read data comes straight from the memory in the ack cycle and is held afterwards.
    assign bus.rdata = rd_done_q ? mem_douta : rdata_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        rd_done_d = 1'b0;
        rdata_d   = rdata_q;
        addra_d   = mem_addra;
        wea_d     = mem_wea;
        dina_d    = mem_dina;
        owner_d   = owner;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    if (grant_c == P_LOADER) begin
                        addra_d = bus.addr1;
                        wea_d   = bus.we1;
                        dina_d  = bus.wdata1;
                    end else begin
                        addra_d = bus.addr0;
                        wea_d   = bus.we0;
                        dina_d  = bus.wdata0;
                    end
                    is_read_d = (wea_d == '0);
                    owner_d   = grant_c;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wea_d = '0;
                if (!is_read_q || (RD_LAT <= 1)) begin
                    state_d   = ST_DONE;
                    ack0_d    = (owner == P_LSU);
                    ack1_d    = (owner == P_LOADER);
                    rd_done_d = is_read_q;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RD_LAT) - CNT_W'(2);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    ack0_d    = (owner == P_LSU);
                    ack1_d    = (owner == P_LOADER);
                    rd_done_d = is_read_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (rd_done_q) begin
                    rdata_d = mem_douta;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Reset clears mem_wea asynchronously, suppressing a write caught in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
            rd_done_q <= 1'b0;
            rdata_q   <= '0;
            mem_addra <= '0;
            mem_wea   <= '0;
            mem_dina  <= '0;
            owner     <= P_LSU;
            bus.ack0  <= 1'b0;
            bus.ack1  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            rd_done_q <= rd_done_d;
            rdata_q   <= rdata_d;
            mem_addra <= addra_d;
            mem_wea   <= wea_d;
            mem_dina  <= dina_d;
            owner     <= owner_d;
            bus.ack0  <= ack0_d;
            bus.ack1  <= ack1_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one RD_LAT=1 and one RD_LAT=3 instance, each on its own memory model.
module tb_dmem_arbiter;
    import kgp_mem_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_clr;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    logic          busy1, owner1, busy3, owner3;
    logic [3:0]    wea1, wea3;
    logic [AW-1:0] addra1, addra3;
    logic [DW-1:0] dina1, dina3, douta1, douta3;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .owner(owner1),
        .mem_wea(wea1), .mem_addra(addra1), .mem_dina(dina1), .mem_douta(douta1)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .busy(busy3), .owner(owner3),
        .mem_wea(wea3), .mem_addra(addra3), .mem_dina(dina3), .mem_douta(douta3)
    );

    // Byte-enable memories with registered read of latency 1 and 3.
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] p3a, p3b;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem1[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (wea1[b]) mem1[addra1[3:0]][8*b +: 8] <= dina1[8*b +: 8];
        end
        douta1 <= mem1[addra1[3:0]];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem3[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (wea3[b]) mem3[addra3[3:0]][8*b +: 8] <= dina3[8*b +: 8];
        end
        p3a    <= mem3[addra3[3:0]];
        p3b    <= p3a;
        douta3 <= p3b;
    end

    function automatic logic get_ack(input int d, input logic p);
        if (d == 1) return p ? bus1.ack1 : bus1.ack0;
        return p ? bus3.ack1 : bus3.ack0;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 1) ? bus1.rdata : bus3.rdata;
    endfunction

    function automatic logic [3:0] get_wea(input int d);
        return (d == 1) ? wea1 : wea3;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 1) ? busy1 : busy3;
    endfunction

    task automatic drive(input int d, input logic p, input logic r, input logic [31:0] a,
                         input logic [3:0] w, input logic [31:0] wd);
        if (d == 1) begin
            if (p) begin bus1.req1 = r; bus1.addr1 = a; bus1.we1 = w; bus1.wdata1 = wd; end
            else   begin bus1.req0 = r; bus1.addr0 = a; bus1.we0 = w; bus1.wdata0 = wd; end
        end else begin
            if (p) begin bus3.req1 = r; bus3.addr1 = a; bus3.we1 = w; bus3.wdata1 = wd; end
            else   begin bus3.req0 = r; bus3.addr0 = a; bus3.we0 = w; bus3.wdata0 = wd; end
        end
    endtask

    // One access from a single port; lat counts cycles from the request cycle to the ack cycle.
    task automatic access(input int d, input logic p, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output int wea_n, output logic [3:0] wea_v, output int busy_n);
        lat = -1; rd = 'x; wea_n = 0; wea_v = '0; busy_n = 0;
        @(posedge clk); #1;
        drive(d, p, 1'b1, a, w, wd);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (get_wea(d) != 4'h0) begin wea_n++; wea_v = get_wea(d); end
            if (get_busy(d)) busy_n++;
            if (get_ack(d, p)) begin lat = k; rd = get_rdata(d); break; end
        end
        @(posedge clk); #1;
        drive(d, p, 1'b0, a, w, wd);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus1.ack0 !== 1'b0) begin n_bad++; $display("FAIL rst_ack0: got %b expected 0", bus1.ack0); end
        n_cmp++; if (bus1.ack1 !== 1'b0) begin n_bad++; $display("FAIL rst_ack1: got %b expected 0", bus1.ack1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy1); end
        n_cmp++; if (owner1 !== 1'b0) begin n_bad++; $display("FAIL rst_owner: got %b expected 0", owner1); end
        n_cmp++; if (wea1 !== 4'h0) begin n_bad++; $display("FAIL rst_wea: got %h expected 0", wea1); end
        n_cmp++; if (addra1 !== 32'h0) begin n_bad++; $display("FAIL rst_addra: got %h expected 0", addra1); end
        n_cmp++; if (dina1 !== 32'h0) begin n_bad++; $display("FAIL rst_dina: got %h expected 0", dina1); end
        n_cmp++; if (bus1.rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h expected 0", bus1.rdata); end
        n_cmp++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL rst_busy3: got %b expected 0", busy3); end
    endtask

    task automatic test_reset_mid_write();
        int lat, wn, bn, acks;
        logic [31:0] rd;
        logic [3:0] wv;
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 32'd1, 4'hF, 32'd5);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (wea1 !== 4'hF) begin n_bad++; $display("FAIL mid_issue_wea: got %h expected f", wea1); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (wea1 !== 4'h0) begin n_bad++; $display("FAIL mid_rst_wea: got %h expected 0", wea1); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b expected 0", busy1); end
        n_cmp++; if (owner1 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_owner: got %b expected 0", owner1); end
        drive(1, 1'b0, 1'b0, 32'd1, 4'hF, 32'd5);
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus1.ack0) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL mid_rst_no_ack: got %0d acks expected 0", acks); end
        access(1, 1'b0, 32'd1, 4'h0, 32'd0, lat, rd, wn, wv, bn);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_rst_suppressed: got %h expected 0", rd); end
    endtask

    task automatic test_write_read();
        int lat, wn, bn;
        logic [31:0] rd;
        logic [3:0] wv;
        access(1, 1'b0, 32'd1, 4'hF, 32'd5, lat, rd, wn, wv, bn);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_lat: got %0d expected 2", lat); end
        n_cmp++; if (wn !== 1) begin n_bad++; $display("FAIL wr_strobe_cycles: got %0d expected 1", wn); end
        n_cmp++; if (wv !== 4'hF) begin n_bad++; $display("FAIL wr_strobe_val: got %h expected f", wv); end
        access(1, 1'b0, 32'd1, 4'h0, 32'd0, lat, rd, wn, wv, bn);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_lat: got %0d expected 2", lat); end
        n_cmp++; if (rd !== 32'd5) begin n_bad++; $display("FAIL rd_data: got %h expected 5", rd); end
        n_cmp++; if (wn !== 0) begin n_bad++; $display("FAIL rd_no_strobe: got %0d expected 0", wn); end
        @(negedge clk);
        n_cmp++; if (bus1.rdata !== 32'd5) begin n_bad++; $display("FAIL rd_hold: got %h expected 5", bus1.rdata); end
    endtask

    task automatic test_byte_enable();
        int lat, wn, bn;
        logic [31:0] rd;
        logic [3:0] wv;
        access(1, 1'b1, 32'd2, 4'hF, 32'hAABBCCDD, lat, rd, wn, wv, bn);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL be_full_lat: got %0d expected 2", lat); end
        access(1, 1'b1, 32'd2, 4'b0001, 32'h00000011, lat, rd, wn, wv, bn);
        n_cmp++; if (wv !== 4'b0001) begin n_bad++; $display("FAIL be_strobe_val: got %h expected 1", wv); end
        access(1, 1'b1, 32'd2, 4'h0, 32'd0, lat, rd, wn, wv, bn);
        n_cmp++; if (rd !== 32'hAABBCC11) begin n_bad++; $display("FAIL be_merge: got %h expected aabbcc11", rd); end
        n_cmp++; if (owner1 !== 1'b1) begin n_bad++; $display("FAIL be_owner: got %b expected 1", owner1); end
        n_cmp++; if (bus1.rdata !== 32'hAABBCC11) begin n_bad++; $display("FAIL be_rdata_hold: got %h expected aabbcc11", bus1.rdata); end
    endtask

    task automatic test_contention();
        int order [4];
        int when [4];
        int n, overlap, dbl;
        logic a0, a1, prev0, prev1;
        n = 0; overlap = 0; dbl = 0; prev0 = 1'b0; prev1 = 1'b0;
        for (int i = 0; i < 4; i++) begin order[i] = -1; when[i] = -1; end
        @(negedge clk);
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b1, 32'd1, 4'h0, 32'd0);
        drive(1, 1'b1, 1'b1, 32'd2, 4'h0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            a0 = bus1.ack0;
            a1 = bus1.ack1;
            if (a0 && a1) overlap++;
            if ((a0 && prev0) || (a1 && prev1)) dbl++;
            if (a0 || a1) begin
                order[n] = a1 ? 1 : 0;
                when[n]  = k;
                n++;
            end
            prev0 = a0;
            prev1 = a1;
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'd1, 4'h0, 32'd0);
        drive(1, 1'b1, 1'b0, 32'd2, 4'h0, 32'd0);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL cont_count: got %0d grants expected 4", n); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (order[i] !== i % 2) begin n_bad++; $display("FAIL cont_order[%0d]: got %0d expected %0d", i, order[i], i % 2); end
            n_cmp++; if (when[i] !== 1 + 3 * i) begin n_bad++; $display("FAIL cont_time[%0d]: got %0d expected %0d", i, when[i], 1 + 3 * i); end
        end
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL cont_overlap: got %0d expected 0", overlap); end
        n_cmp++; if (dbl !== 0) begin n_bad++; $display("FAIL cont_ack_width: got %0d expected 0", dbl); end
        @(negedge clk);
    endtask

    task automatic test_isolation();
        int lat, wn, bn, t0, t1;
        logic [31:0] rd, rd0, rd1;
        logic [3:0] wv;
        t0 = -1; t1 = -1; rd0 = 'x; rd1 = 'x;
        access(1, 1'b0, 32'd1, 4'hF, 32'd10, lat, rd, wn, wv, bn);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 32'd1, 4'h0, 32'd0);
        for (int k = 0; k < 20; k++) begin
            if (k == 1) drive(1, 1'b1, 1'b1, 32'd2, 4'hF, 32'd7);
            @(negedge clk);
            if (bus1.ack0) begin t0 = k; rd0 = bus1.rdata; end
            if (bus1.ack1) begin t1 = k; rd1 = bus1.rdata; end
            @(posedge clk); #1;
            if (t0 == k) drive(1, 1'b0, 1'b0, 32'd1, 4'h0, 32'd0);
            if (t1 == k) begin drive(1, 1'b1, 1'b0, 32'd2, 4'hF, 32'd7); break; end
        end
        n_cmp++; if (t0 !== 2) begin n_bad++; $display("FAIL iso_ack0_time: got %0d expected 2", t0); end
        n_cmp++; if (rd0 !== 32'd10) begin n_bad++; $display("FAIL iso_rdata_ack0: got %h expected a", rd0); end
        n_cmp++; if (t1 !== 5) begin n_bad++; $display("FAIL iso_ack1_time: got %0d expected 5", t1); end
        n_cmp++; if (rd1 !== 32'd10) begin n_bad++; $display("FAIL iso_rdata_ack1: got %h expected a", rd1); end
        @(negedge clk);
        n_cmp++; if (bus1.rdata !== 32'd10) begin n_bad++; $display("FAIL iso_rdata_after: got %h expected a", bus1.rdata); end
        access(1, 1'b1, 32'd2, 4'h0, 32'd0, lat, rd, wn, wv, bn);
        n_cmp++; if (rd !== 32'd7) begin n_bad++; $display("FAIL iso_write_landed: got %h expected 7", rd); end
    endtask

    task automatic test_rdlat3();
        int lat, wn, bn;
        logic [31:0] rd;
        logic [3:0] wv;
        access(3, 1'b0, 32'd1, 4'hF, 32'd10, lat, rd, wn, wv, bn);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lat3_wr_lat: got %0d expected 2", lat); end
        n_cmp++; if (bn !== 2) begin n_bad++; $display("FAIL lat3_wr_busy: got %0d expected 2", bn); end
        access(3, 1'b0, 32'd1, 4'h0, 32'd0, lat, rd, wn, wv, bn);
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL lat3_rd_lat: got %0d expected 4", lat); end
        n_cmp++; if (rd !== 32'd10) begin n_bad++; $display("FAIL lat3_rd_data: got %h expected a", rd); end
        n_cmp++; if (bn !== 4) begin n_bad++; $display("FAIL lat3_rd_busy: got %0d expected 4", bn); end
        n_cmp++; if (owner3 !== 1'b0) begin n_bad++; $display("FAIL lat3_owner: got %b expected 0", owner3); end
    endtask

    initial begin
        rst_n   = 1'b0;
        mem_clr = 1'b1;
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b1, 1'b0, '0, '0, '0);
        drive(3, 1'b0, 1'b0, '0, '0, '0);
        drive(3, 1'b1, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        mem_clr = 1'b0;

        test_reset();
        test_reset_mid_write();
        test_write_read();
        test_byte_enable();
        test_contention();
        test_isolation();
        test_rdlat3();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
